// File: rtl/siso_word_deser.sv
// Serial-to-parallel word assembler with a one-entry valid/ready output register.
// Define SIPO_PARITY_EN to expect an even-parity bit after each WIDTH-bit frame.
module siso_word_deser #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_valid,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             overflow,
   input  logic             clr_ovf,
   output logic             parity_err
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SIPO_PARITY_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1
   } state_t;
`endif

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] sreg_nxt;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] word;
   logic             deliver;
   logic             load;
   logic             drop;
`ifdef SIPO_PARITY_EN
   logic             perr;
`endif

   assign shifted = {sreg[WIDTH-2:0], sin};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         sreg  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         sreg  <= sreg_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sreg_nxt  = sreg;
      word      = sreg;
      deliver   = 1'b0;
`ifdef SIPO_PARITY_EN
      perr      = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (sin_valid) begin
               // first accepted bit ends up in the MSB after WIDTH-1 more shifts
               sreg_nxt  = {{(WIDTH-1){1'b0}}, sin};
               cnt_nxt   = CW'(1);
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (sin_valid) begin
               sreg_nxt = shifted;
               if (cnt == LAST) begin
                  cnt_nxt = '0;
`ifdef SIPO_PARITY_EN
                  state_nxt = PAR;
`else
                  state_nxt = IDLE;
                  deliver   = 1'b1;
                  word      = shifted;
`endif
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
         end
`ifdef SIPO_PARITY_EN
         PAR: begin
            if (sin_valid) begin
               state_nxt = IDLE;
               deliver   = 1'b1;
               word      = sreg;
               perr      = (^sreg) ^ sin;
            end
         end
`endif
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            sreg_nxt  = '0;
         end
      endcase
   end

   // a full register that drains on the same edge still accepts the new word
   assign load = deliver && (!dout_valid || dout_ready);
   assign drop = deliver && dout_valid && !dout_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (load) begin
            dout       <= word;
            dout_valid <= 1'b1;
         end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
         end
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

`ifdef SIPO_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_err <= 1'b0;
      end else if (load) begin
         parity_err <= perr;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_siso_word_deser.sv
// Directed, table-driven bench for siso_word_deser (WIDTH=8).
// Covers streaming, gaps, back-pressure, overflow, reset mid-word, parity.
module tb_siso_word_deser;

   logic       clk;
   logic       rst;
   logic       sin;
   logic       sin_valid;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready;
   logic       overflow;
   logic       clr_ovf;
   logic       parity_err;

   int pass_cnt = 0;
   int total_cnt = 0;

   siso_word_deser #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .sin        (sin),
      .sin_valid  (sin_valid),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .overflow   (overflow),
      .clr_ovf    (clr_ovf),
      .parity_err (parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       sin;
      logic       sv;
      logic       rdy;
      logic       clr;
      logic [7:0] d;
      logic       v;
      logic       o;
      logic       p;
   } vec_t;

   vec_t vecs[$];
   int   vec_id = 0;

   task automatic check(input string name, input logic [7:0] d, input logic v,
                        input logic o, input logic p);
      total_cnt++;
      if (dout === d && dout_valid === v && overflow === o && parity_err === p) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got dout=%h valid=%b ovf=%b perr=%b, want dout=%h valid=%b ovf=%b perr=%b",
                  name, dout, dout_valid, overflow, parity_err, d, v, o, p);
      end
   endtask

   task automatic add(input logic s, input logic sv, input logic rdy, input logic clr,
                      input logic [7:0] d, input logic v, input logic o, input logic p);
      vec_t t;
      t.sin = s; t.sv = sv; t.rdy = rdy; t.clr = clr;
      t.d = d; t.v = v; t.o = o; t.p = p;
      vecs.push_back(t);
   endtask

   // 8 data bits MSB first; body = expectations after edges 1..7, last = after edge 8
   task automatic add_word(input logic [7:0] w, input logic rdy_body, input logic rdy_last,
                           input logic clr_last, input logic [7:0] d_body, input logic v_body,
                           input logic o_body, input logic [7:0] d_last, input logic v_last,
                           input logic o_last);
      for (int i = 7; i >= 1; i--) begin
         add(w[i], 1'b1, rdy_body, 1'b0, d_body, v_body, o_body, 1'b0);
      end
      add(w[0], 1'b1, rdy_last, clr_last, d_last, v_last, o_last, 1'b0);
   endtask

   task automatic run_vecs();
      foreach (vecs[k]) begin
         sin        = vecs[k].sin;
         sin_valid  = vecs[k].sv;
         dout_ready = vecs[k].rdy;
         clr_ovf    = vecs[k].clr;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", vec_id), vecs[k].d, vecs[k].v, vecs[k].o, vecs[k].p);
         vec_id++;
      end
      vecs.delete();
      sin_valid = 1'b0;
      clr_ovf   = 1'b0;
   endtask

   initial begin
      logic [7:0] w;
      rst        = 1'b1;
      sin        = 1'b0;
      sin_valid  = 1'b0;
      dout_ready = 1'b0;
      clr_ovf    = 1'b0;
      #1;
      check("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      check("post_reset", 8'h00, 1'b0, 1'b0, 1'b0);

`ifdef SIPO_PARITY_EN
      w = 8'hB2;
      for (int i = 7; i >= 0; i--) add(w[i], 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 8'hB2, 1'b1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 8'hB2, 1'b0, 1'b0, 1'b0);
      w = 8'h4B;
      for (int i = 7; i >= 0; i--) add(w[i], 1'b1, 1'b1, 1'b0, 8'hB2, 1'b0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 8'h4B, 1'b1, 1'b0, 1'b0);
      w = 8'hB2;
      for (int i = 7; i >= 0; i--) add(w[i], 1'b1, 1'b1, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b1, 1'b1, 1'b0, 8'hB2, 1'b1, 1'b0, 1'b1);
      add(1'b0, 1'b0, 1'b1, 1'b0, 8'hB2, 1'b0, 1'b0, 1'b1);
      run_vecs();
`else
      // full rate, ready high
      add_word(8'hB2, 1, 1, 0, 8'h00, 0, 0, 8'hB2, 1, 0);
      add(0, 0, 1, 0, 8'hB2, 0, 0, 0);
      // gapped: idle cycles carry inverted data that must be ignored
      w = 8'hB2;
      for (int i = 7; i >= 0; i--) begin
         add(w[i], 1'b1, 1'b1, 1'b0, 8'hB2, (i == 0), 1'b0, 1'b0);
         add(!w[i], 1'b0, 1'b1, 1'b0, 8'hB2, 1'b0, 1'b0, 1'b0);
      end
      // back-pressure: second word dropped, then drain with clear
      add_word(8'hA5, 0, 0, 0, 8'hB2, 0, 0, 8'hA5, 1, 0);
      add_word(8'h3C, 0, 0, 0, 8'hA5, 1, 0, 8'hA5, 1, 1);
      add(0, 0, 1, 1, 8'hA5, 0, 0, 0);
      // continuous stream
      add_word(8'h01, 1, 1, 0, 8'hA5, 0, 0, 8'h01, 1, 0);
      add_word(8'h02, 1, 1, 0, 8'h01, 0, 0, 8'h02, 1, 0);
      add_word(8'h03, 1, 1, 0, 8'h02, 0, 0, 8'h03, 1, 0);
      add(0, 0, 1, 0, 8'h03, 0, 0, 0);
      // completion and drain on the same edge: no bubble, no overflow
      add_word(8'hC3, 0, 0, 0, 8'h03, 0, 0, 8'hC3, 1, 0);
      add_word(8'h96, 0, 1, 0, 8'hC3, 1, 0, 8'h96, 1, 0);
      add(0, 0, 1, 0, 8'h96, 0, 0, 0);
      // set wins over clear on the same edge
      add_word(8'h11, 0, 0, 0, 8'h96, 0, 0, 8'h11, 1, 0);
      add_word(8'h22, 0, 0, 1, 8'h11, 1, 0, 8'h11, 1, 1);
      add(0, 0, 0, 1, 8'h11, 1, 0, 0);
      add(0, 0, 1, 0, 8'h11, 0, 0, 0);
      // partial word before reset
      add(1, 1, 1, 0, 8'h11, 0, 0, 0);
      add(0, 1, 1, 0, 8'h11, 0, 0, 0);
      add(1, 1, 1, 0, 8'h11, 0, 0, 0);
      add(1, 1, 1, 0, 8'h11, 0, 0, 0);
      add(0, 1, 1, 0, 8'h11, 0, 0, 0);
      run_vecs();

      #2;
      rst = 1'b1;
      #1;
      check("rst_midword", 8'h00, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      check("rst_held", 8'h00, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      add_word(8'hFF, 1, 1, 0, 8'h00, 0, 0, 8'hFF, 1, 0);
      add(0, 0, 1, 0, 8'hFF, 0, 0, 0);
      run_vecs();
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
